lfo_generator: RTL and testbench

- Parametrised low-frequency oscillator for modulation effects such as tremolo, vibrato and auto-wah.
- Free-running counter core with a programmable prescaler, programmable step size and four waveform modes.
- Output drives gain/modulation inputs of effect blocks in the pedal chain. A one-cycle tick marks each output update.

---
 rtl/lfo_pkg.sv | 13 +
 rtl/lfo_prescaler.sv | 26 ++
 rtl/lfo_generator.sv | 147 ++++++++++++++
 tb/tb_lfo_generator.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfo_pkg.sv
// rtl/lfo_pkg.sv - shared types and constants for the LFO generator
package lfo_pkg;

  typedef enum logic [1:0] {
    LFO_TRI  = 2'd0,
    LFO_SAW  = 2'd1,
    LFO_SQR  = 2'd2,
    LFO_HOLD = 2'd3
  } lfo_mode_e;

  localparam int DEPTH_W = 8;

endpackage

// File: rtl/lfo_prescaler.sv
// rtl/lfo_prescaler.sv - programmable update-rate prescaler, one update every div+1 enabled cycles
module lfo_prescaler #(
  parameter int DIV_W = 12
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             upd
);

  logic [DIV_W-1:0] r_cnt;

  // div is compared live so lowering it below the count terminates immediately
  assign upd = en && (r_cnt >= div);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (en) begin
      if (upd) r_cnt <= '0;
      else     r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/lfo_generator.sv
// rtl/lfo_generator.sv - LFO waveform core (TRI/SAW/SQR/HOLD); macro LFO_DEPTH_EN adds depth scaling stage
import lfo_pkg::*;

module lfo_generator #(
  parameter int WIDTH  = 16,
  parameter int DIV_W  = 12,
  parameter int STEP_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              en,
  input  lfo_mode_e         mode,
  input  logic [DIV_W-1:0]  div,
  input  logic [STEP_W-1:0] step,
`ifdef LFO_DEPTH_EN
  input  logic [DEPTH_W-1:0] depth,
`endif
  output logic [WIDTH-1:0]  val,
  output logic              tick,
  output logic              dir
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic             w_upd;
  logic             w_mode_chg;
  logic             w_restart;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_dir_nxt;
  logic [WIDTH-1:0] w_core_nxt;

  logic [WIDTH-1:0] r_acc;
  logic             r_dir;
  logic [WIDTH-1:0] r_core;
  logic             r_tick;
  lfo_mode_e        r_mode_prev;
  logic             r_restart_pend;

  lfo_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (en),
    .div   (div),
    .upd   (w_upd)
  );

  assign w_step     = WIDTH'(step);
  assign w_mode_chg = (mode != r_mode_prev);
  // a mode change remembered until the next update, which restarts instead of stepping
  assign w_restart  = r_restart_pend || w_mode_chg;

  always_comb begin
    w_acc_nxt = r_acc;
    w_dir_nxt = r_dir;
    if (w_restart) begin
      w_acc_nxt = '0;
      w_dir_nxt = 1'b1;
    end else if (w_step != '0) begin
      case (mode)
        LFO_TRI, LFO_SQR: begin
          if (r_dir) begin
            if (r_acc >= MAX - w_step) begin
              w_acc_nxt = MAX;
              w_dir_nxt = 1'b0;
            end else begin
              w_acc_nxt = r_acc + w_step;
            end
          end else begin
            if (r_acc <= w_step) begin
              w_acc_nxt = '0;
              w_dir_nxt = 1'b1;
            end else begin
              w_acc_nxt = r_acc - w_step;
            end
          end
        end
        LFO_SAW: begin
          w_dir_nxt = 1'b1;
          if (r_acc > MAX - w_step) w_acc_nxt = '0;
          else                      w_acc_nxt = r_acc + w_step;
        end
        default: begin
          w_acc_nxt = r_acc;
          w_dir_nxt = r_dir;
        end
      endcase
    end
  end

  assign w_core_nxt = (mode == LFO_SQR) ? (w_dir_nxt ? MAX : '0) : w_acc_nxt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_acc          <= '0;
      r_dir          <= 1'b1;
      r_core         <= '0;
      r_tick         <= 1'b0;
      r_mode_prev    <= mode;
      r_restart_pend <= 1'b0;
    end else begin
      r_tick      <= w_upd;
      r_mode_prev <= mode;
      if (w_upd) begin
        r_acc          <= w_acc_nxt;
        r_dir          <= w_dir_nxt;
        r_core         <= w_core_nxt;
        r_restart_pend <= 1'b0;
      end else if (w_mode_chg) begin
        r_restart_pend <= 1'b1;
      end
    end
  end

`ifdef LFO_DEPTH_EN
  logic [WIDTH+DEPTH_W-1:0] w_prod;
  logic [WIDTH-1:0]         w_scaled;
  logic [WIDTH-1:0]         r_val_d;
  logic                     r_tick_d;
  logic                     r_dir_d;

  // attenuate downward from MAX so depth=0 leaves the effect unmodulated
  assign w_prod   = (WIDTH+DEPTH_W)'(MAX - r_core) * (WIDTH+DEPTH_W)'(depth);
  assign w_scaled = WIDTH'(w_prod >> DEPTH_W);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_val_d  <= MAX;
      r_tick_d <= 1'b0;
      r_dir_d  <= 1'b1;
    end else begin
      r_val_d  <= MAX - w_scaled;
      r_tick_d <= r_tick;
      r_dir_d  <= r_dir;
    end
  end

  assign val  = r_val_d;
  assign tick = r_tick_d;
  assign dir  = r_dir_d;
`else
  assign val  = r_core;
  assign tick = r_tick;
  assign dir  = r_dir;
`endif

endmodule

// File: tb/tb_lfo_generator.sv
// tb/tb_lfo_generator.sv - directed self-checking bench for lfo_generator
import lfo_pkg::*;

module tb_lfo_generator;

  logic        CLK;
  logic        RESET;
  logic        en;
  lfo_mode_e   mode;
  logic [11:0] div;
  logic [15:0] step;
  logic [15:0] val;
  logic        tick;
  logic        dir;
`ifdef LFO_DEPTH_EN
  logic [7:0]  depth;
`endif

  int checks;
  int failures;

  lfo_generator #(.WIDTH(16), .DIV_W(12), .STEP_W(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (en),
    .mode  (mode),
    .div   (div),
    .step  (step),
`ifdef LFO_DEPTH_EN
    .depth (depth),
`endif
    .val   (val),
    .tick  (tick),
    .dir   (dir)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input lfo_mode_e m, input logic [15:0] s, input logic [11:0] d);
    RESET = 1'b1;
    en    = 1'b1;
    mode  = m;
    step  = s;
    div   = d;
    cyc(3);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp_val;
`ifdef LFO_DEPTH_EN
    exp_val = 16'hFFFF;
`else
    exp_val = 16'h0000;
`endif
    do_reset(LFO_TRI, 16'd1, 12'd0);
    checks++;
    if (val !== exp_val) begin
      failures++;
      $display("FAIL reset_val got=%h exp=%h", val, exp_val);
    end
    checks++;
    if (dir !== 1'b1) begin
      failures++;
      $display("FAIL reset_dir got=%b exp=1", dir);
    end
    checks++;
    if (tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_tick got=%b exp=0", tick);
    end
  endtask

  task automatic test_tri_ramp();
    do_reset(LFO_TRI, 16'd1, 12'd0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      checks++;
      if (val !== 16'(k) || tick !== 1'b1 || dir !== 1'b1) begin
        failures++;
        $display("FAIL tri_ramp k=%0d got val=%h tick=%b dir=%b exp val=%h tick=1 dir=1", k, val, tick, dir, 16'(k));
      end
    end
  endtask

  task automatic test_tri_bounds();
    logic [15:0] ev [6];
    logic        ed [6];
    int          nc [6];
    ev = '{16'hFFF0, 16'hFFFF, 16'hFFEF, 16'h000F, 16'h0000, 16'h0010};
    ed = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    nc = '{4095, 1, 1, 4094, 1, 1};
    do_reset(LFO_TRI, 16'h0010, 12'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(nc[i]);
      checks++;
      if (val !== ev[i] || dir !== ed[i]) begin
        failures++;
        $display("FAIL tri_bounds i=%0d got val=%h dir=%b exp val=%h dir=%b", i, val, dir, ev[i], ed[i]);
      end
    end
  endtask

  task automatic test_saw();
    logic [15:0] ev;
    logic        et;
    do_reset(LFO_SAW, 16'h8000, 12'd3);
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      et = (k % 4 == 0);
      ev = ((k / 4) % 2 == 1) ? 16'h8000 : 16'h0000;
      checks++;
      if (val !== ev || tick !== et || dir !== 1'b1) begin
        failures++;
        $display("FAIL saw k=%0d got val=%h tick=%b dir=%b exp val=%h tick=%b dir=1", k, val, tick, dir, ev, et);
      end
    end
  endtask

  task automatic test_sqr_hold();
    logic [15:0] ev [5];
    logic        ed [5];
    ev = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    ed = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset(LFO_SQR, 16'h4000, 12'd0);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      checks++;
      if (val !== ev[k] || dir !== ed[k]) begin
        failures++;
        $display("FAIL sqr k=%0d got val=%h dir=%b exp val=%h dir=%b", k, val, dir, ev[k], ed[k]);
      end
    end
    mode = LFO_HOLD;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      checks++;
      if (val !== 16'h0000 || dir !== 1'b1 || tick !== 1'b1) begin
        failures++;
        $display("FAIL hold k=%0d got val=%h dir=%b tick=%b exp val=0000 dir=1 tick=1", k, val, dir, tick);
      end
    end
  endtask

  task automatic test_step_zero();
    do_reset(LFO_TRI, 16'h8000, 12'd0);
    cyc(2);
    checks++;
    if (val !== 16'hFFFF || dir !== 1'b0) begin
      failures++;
      $display("FAIL step0_pre got val=%h dir=%b exp val=ffff dir=0", val, dir);
    end
    step = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      checks++;
      if (val !== 16'hFFFF || dir !== 1'b0 || tick !== 1'b1) begin
        failures++;
        $display("FAIL step0 k=%0d got val=%h dir=%b tick=%b exp val=ffff dir=0 tick=1", k, val, dir, tick);
      end
    end
  endtask

  task automatic test_enable_reset();
    int ticks_seen;
    do_reset(LFO_TRI, 16'd1, 12'd5);
    cyc(2);
    en = 1'b0;
    ticks_seen = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      if (tick === 1'b1) ticks_seen++;
    end
    checks++;
    if (ticks_seen != 0 || val !== 16'h0000) begin
      failures++;
      $display("FAIL en_hold got ticks=%0d val=%h exp ticks=0 val=0000", ticks_seen, val);
    end
    en = 1'b1;
    cyc(3);
    checks++;
    if (tick !== 1'b0 || val !== 16'h0000) begin
      failures++;
      $display("FAIL en_resume_early got tick=%b val=%h exp tick=0 val=0000", tick, val);
    end
    cyc(1);
    checks++;
    if (tick !== 1'b1 || val !== 16'h0001) begin
      failures++;
      $display("FAIL en_resume_upd got tick=%b val=%h exp tick=1 val=0001", tick, val);
    end
    cyc(2);
    RESET = 1'b1;
    cyc(1);
    checks++;
    if (val !== 16'h0000 || dir !== 1'b1 || tick !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got val=%h dir=%b tick=%b exp val=0000 dir=1 tick=0", val, dir, tick);
    end
    RESET = 1'b0;
  endtask

`ifdef LFO_DEPTH_EN
  task automatic test_depth();
    logic [15:0] ev [5];
    logic        et [5];
    logic        ed [5];
    ev = '{16'h8000, 16'hC000, 16'hFFFF, 16'hBFFF, 16'h8000};
    et = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ed = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    depth = 8'd128;
    do_reset(LFO_TRI, 16'h8000, 12'd0);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      checks++;
      if (val !== ev[k] || tick !== et[k] || dir !== ed[k]) begin
        failures++;
        $display("FAIL depth k=%0d got val=%h tick=%b dir=%b exp val=%h tick=%b dir=%b", k, val, tick, dir, ev[k], et[k], ed[k]);
      end
    end
    depth = 8'd0;
    cyc(1);
    checks++;
    if (val !== 16'hFFFF) begin
      failures++;
      $display("FAIL depth0 got val=%h exp ffff", val);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    RESET    = 1'b1;
    en       = 1'b0;
    mode     = LFO_TRI;
    div      = '0;
    step     = '0;
`ifdef LFO_DEPTH_EN
    depth    = 8'd128;
`endif
    test_reset();
`ifdef LFO_DEPTH_EN
    test_depth();
`else
    test_tri_ramp();
    test_tri_bounds();
    test_saw();
    test_sqr_hold();
    test_step_zero();
    test_enable_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
